// File: rtl/ipm_encode.sv
// ipm_encode: sequential v-share inner-product-masking encoder over GF(2^8) with one shared multiplier
module ipm_encode #(
   parameter int v = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [7:0]     x,
   input  logic [v*8-1:0] L,
   input  logic           rnd_valid,
   output logic           rnd_ready,
   input  logic [7:0]     rnd,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [v*8-1:0] z,
   output logic           busy
);
   localparam int IW = $clog2(v);
   localparam logic [1:0] IDLE = 2'd0, GATHER = 2'd1, DONE = 2'd2;
   localparam logic [IW-1:0] LAST = IW'(v - 1);
   logic [1:0] state;
   logic [7:0] acc, nacc;
   logic [IW-1:0] idx;
   logic [v-1:0][7:0] lreg, zr;
   function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ t : p;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction
   // running share-0 value after folding in the current random byte
   always_comb nacc = acc ^ gmul8(lreg[idx], rnd);
   // handshake FSM: latch secret, gather v-1 random shares, present encoding
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         idx   <= '0;
         lreg  <= '0;
         zr    <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               acc   <= x;
               lreg  <= L;
               idx   <= IW'(1);
               state <= GATHER;
            end
            GATHER: if (rnd_valid) begin
               zr[idx] <= rnd;
               acc     <= nacc;
               idx     <= (idx == LAST) ? idx : idx + IW'(1);
               if (idx == LAST) begin
                  zr[0] <= nacc;
                  state <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   assign in_ready  = state == IDLE;
   assign rnd_ready = state == GATHER;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;
   assign z         = zr;
endmodule

// File: tb/tb_ipm_encode.sv
// tb_ipm_encode: directed and randomized checks of ipm_encode for v = 2, 3, 5 against a GF(2^8) model
module tb_ipm_encode;
   logic clk = 1'b0, rst, iv, rv, ordy;
   logic [7:0] x, rnd;
   logic [39:0] lv;
   int sel, tests = 0, failed = 0;
   logic ir2, rr2, ov2, b2, ir3, rr3, ov3, b3, ir5, rr5, ov5, b5;
   logic [15:0] z2;
   logic [23:0] z3;
   logic [39:0] z5;
   logic in_ready_s, rnd_ready_s, out_valid_s, busy_s;
   logic [39:0] z_s;
   always #5 clk = ~clk;
   ipm_encode #(.v(2)) dut2 (.clk(clk), .rst(rst), .in_valid(iv && sel == 2), .in_ready(ir2), .x(x), .L(lv[15:0]),
      .rnd_valid(rv), .rnd_ready(rr2), .rnd(rnd), .out_valid(ov2), .out_ready(ordy), .z(z2), .busy(b2));
   ipm_encode #(.v(3)) dut3 (.clk(clk), .rst(rst), .in_valid(iv && sel == 3), .in_ready(ir3), .x(x), .L(lv[23:0]),
      .rnd_valid(rv), .rnd_ready(rr3), .rnd(rnd), .out_valid(ov3), .out_ready(ordy), .z(z3), .busy(b3));
   ipm_encode #(.v(5)) dut5 (.clk(clk), .rst(rst), .in_valid(iv && sel == 5), .in_ready(ir5), .x(x), .L(lv),
      .rnd_valid(rv), .rnd_ready(rr5), .rnd(rnd), .out_valid(ov5), .out_ready(ordy), .z(z5), .busy(b5));
   assign in_ready_s  = sel == 2 ? ir2 : sel == 5 ? ir5 : ir3;
   assign rnd_ready_s = sel == 2 ? rr2 : sel == 5 ? rr5 : rr3;
   assign out_valid_s = sel == 2 ? ov2 : sel == 5 ? ov5 : ov3;
   assign busy_s      = sel == 2 ? b2 : sel == 5 ? b5 : b3;
   assign z_s         = sel == 2 ? {24'h0, z2} : sel == 5 ? z5 : {16'h0, z3};

   // carry-less product followed by long division by 0x11B
   function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
      for (int k = 14; k >= 8; k--) if (p[k]) p ^= 15'h11B << (k - 8);
      return p[7:0];
   endfunction
   function automatic logic [39:0] ref_z(input int vv, input logic [7:0] xx, input logic [39:0] ll, input logic [39:0] rr);
      logic [39:0] zz;
      logic [7:0] s;
      zz = '0;
      s = xx;
      for (int i = 1; i < vv; i++) begin
         zz[i*8 +: 8] = rr[i*8 +: 8];
         s ^= gf(ll[i*8 +: 8], rr[i*8 +: 8]);
      end
      zz[7:0] = s;
      return zz;
   endfunction
   function automatic logic [7:0] decode(input int vv, input logic [39:0] ll, input logic [39:0] zz);
      logic [7:0] d;
      d = zz[7:0];
      for (int i = 1; i < vv; i++) d ^= gf(ll[i*8 +: 8], zz[i*8 +: 8]);
      return d;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic encode(input int vv, input logic [7:0] xx, input logic [39:0] ll, input logic [39:0] rr,
                         input int stall_at, input int nstall, input int hold);
      logic [39:0] exp_z, zh;
      int lat;
      sel = vv;
      exp_z = ref_z(vv, xx, ll, rr);
      @(negedge clk);
      chk("in_ready_idle", in_ready_s, 1);
      x = xx;
      lv = ll;
      iv = 1;
      @(negedge clk);
      iv = 0;
      x = 8'($urandom);
      lv = {8'($urandom), 32'($urandom)};
      lat = 1;
      for (int i = 1; i < vv; i++) begin
         for (int s = 0; s < ((i == stall_at) ? nstall : 0); s++) begin
            chk("rnd_ready_stall", rnd_ready_s, 1);
            chk("out_valid_stall", out_valid_s, 0);
            @(negedge clk);
            lat++;
         end
         chk("rnd_ready_gather", rnd_ready_s, 1);
         chk("in_ready_gather", in_ready_s, 0);
         chk("out_valid_gather", out_valid_s, 0);
         chk("busy_gather", busy_s, 1);
         rnd = rr[i*8 +: 8];
         rv = 1;
         @(negedge clk);
         rv = 0;
         rnd = 8'($urandom);
         lat++;
      end
      while (out_valid_s !== 1'b1 && lat < vv + nstall + 8) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 64'(lat), 64'(vv + nstall));
      chk("z", z_s, exp_z);
      chk("decode", decode(vv, ll, z_s), xx);
      zh = z_s;
      rv = 1;
      repeat (hold) begin
         @(negedge clk);
         chk("hold_z", z_s, zh);
         chk("hold_out_valid", out_valid_s, 1);
         chk("hold_in_ready", in_ready_s, 0);
         chk("hold_rnd_ready", rnd_ready_s, 0);
      end
      rv = 0;
      ordy = 1;
      @(negedge clk);
      ordy = 0;
      chk("release_in_ready", in_ready_s, 1);
      chk("release_out_valid", out_valid_s, 0);
      chk("release_busy", busy_s, 0);
      chk("release_z_kept", z_s, exp_z);
   endtask

   initial begin
      sel = 3;
      rst = 1; iv = 0; rv = 0; ordy = 0; x = 0; rnd = 0; lv = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      chk("rst_in_ready", in_ready_s, 1);
      chk("rst_rnd_ready", rnd_ready_s, 0);
      chk("rst_out_valid", out_valid_s, 0);
      chk("rst_busy", busy_s, 0);
      chk("rst_z3", z_s, 0);
      chk("rst_z2_z5", {z2, z5}, 0);
      // worked example with and without a two-cycle gap
      encode(3, 8'h57, 40'h0000_0302_00, 40'h0000_1083_00, 0, 0, 0);
      chk("tp_const", z_s, 40'h10837A);
      encode(3, 8'h57, 40'h0000_0302_00, 40'h0000_1083_00, 2, 2, 0);
      chk("tp_stall_const", z_s, 40'h10837A);
      // zero randomness leaves the secret in share 0
      encode(3, 8'hA5, 40'h0000_C7E1_00, 40'h0, 0, 0, 0);
      chk("zero_rnd", z_s, 40'h0000A5);
      // output backpressure for 10 cycles with rnd offered
      encode(3, 8'h3C, 40'h0000_1B8D_00, 40'h0000_5AF0_00, 1, 1, 10);
      // reset mid-gather discards the in-flight encoding
      @(negedge clk);
      x = 8'hC3; lv = 40'h0000_0907_00; iv = 1;
      @(negedge clk);
      iv = 0; rnd = 8'hEE; rv = 1;
      @(negedge clk);
      rv = 0;
      chk("pre_rst_share1", z_s[15:8], 8'hEE);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("midrst_in_ready", in_ready_s, 1);
      chk("midrst_rnd_ready", rnd_ready_s, 0);
      chk("midrst_out_valid", out_valid_s, 0);
      chk("midrst_busy", busy_s, 0);
      chk("midrst_z", z_s, 0);
      encode(3, 8'h11, 40'h0000_4422_00, 40'h0000_9966_00, 0, 0, 0);
      // other share counts
      encode(2, 8'h57, 40'h0000_0002_00, 40'h0000_0083_00, 0, 0, 0);
      chk("v2_const", z_s, 40'h834A);
      encode(5, 8'hD2, 40'h0F0E0D0C_00, 40'h44332211_00, 3, 2, 3);
      // randomized sweep
      for (int n = 0; n < 1000; n++)
         encode(3, 8'($urandom), {8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)},
                int'($urandom_range(1, 2)), int'($urandom_range(0, 2)), 0);
      for (int n = 0; n < 60; n++) begin
         encode(2, 8'($urandom), {8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)},
                1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         encode(5, 8'($urandom), {8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)},
                int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/ipm_encode.md
# ipm_encode

Sequential IPM (inner-product masking) encoder feeding the RED masked-arithmetic datapath. It takes one secret byte and the public vector L, draws v-1 random bytes over a handshake, and produces a v-share IPM encoding z with x = z_0 ^ XOR_{i=1..v-1} L_i·z_i in GF(2^8). Its z bus is the share-vector source for the homogenization and multiplication stages. A single shared gmul8 is reused over v-1 cycles, trading area for latency.

## Interface
- v, default 3, number of shares; legal range v >= 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  secret byte and L are valid
- in_ready  out  1  encoder can accept a new secret
- x  in  8  secret byte
- L  in  v*8  public IPM vector, byte i = L[(i+1)*8-1:i*8]; byte 0 ignored, treated as 1
- rnd_valid  in  1  random byte valid
- rnd_ready  out  1  encoder consumes rnd this cycle if rnd_valid
- rnd  in  8  fresh random byte
- out_valid  out  1  z holds a complete encoding
- out_ready  in  1  downstream accepts z
- z  out  v*8  shares, byte i = z[(i+1)*8-1:i*8]
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, GATHER, DONE.
- IDLE: in_ready=1. On in_valid: latch x into acc, latch L bytes 1..v-1 into Lreg, idx<=1, go GATHER. Inputs x and L are sampled only at this handshake; later changes are ignored.
- GATHER: rnd_ready=1, in_ready=0. Each cycle with rnd_valid:
  - z byte idx <= rnd
  - acc <= acc ^ gmul8(Lreg[idx], rnd)
  - idx <= idx+1
- Without rnd_valid, all state holds. Gaps of any length are allowed.
- When the random byte for idx = v-1 is accepted: z byte 0 <= acc ^ gmul8(Lreg[v-1], rnd), the full updated value, then go DONE.
- DONE: out_valid=1, z stable. On out_ready, go IDLE. With out_ready held low, z and out_valid hold indefinitely.
- Arithmetic uses GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B), via the codebase gmul8. Addition is XOR.
- idx is a counter of width clog2(v). It never wraps, because the exit is taken at v-1.
- in_ready, rnd_ready and out_valid are mutually exclusive, and each is decoded directly from state.
- Reset at any time: state<=IDLE, acc, idx, Lreg and z <= 0. Any in-flight encoding is discarded and no partial z is presented.
- rnd bytes offered while in IDLE or DONE are not consumed (rnd_ready=0).

## Timing
- Reset values: in_ready=1, rnd_ready=0, out_valid=0, busy=0, z=0.
- Latency with no stalls: in handshake at cycle T, random bytes accepted at T+1..T+v-1, out_valid=1 from T+v.
- Throughput: one encoding per v+1 cycles with no stalls, because IDLE costs one cycle after the out handshake.
- Each stall cycle on rnd_valid adds one cycle of latency.
- z bytes 1..v-1 change only in GATHER. z byte 0 changes only on the GATHER→DONE transition.

## Test plan
- v=3, x=0x57, L=(—,0x02,0x03), rnd 0x83 then 0x10, no stalls → out_valid at T+3, z = 0x10_83_7A (z0 = 0x57^0x1D^0x30).
- Same inputs, rnd_valid low for 2 cycles between the two bytes → identical z, out_valid at T+5, rnd_ready high throughout GATHER.
- All rnd = 0x00, x=0xA5 → z0=0xA5, other shares 0. Also check the decode identity XOR L_i·z_i = x for 1000 random x, L and rnd.
- out_ready held low for 10 cycles in DONE → z and out_valid stable, in_ready=0, offered rnd not consumed. Release → IDLE next cycle, in_ready=1.
- rst asserted in GATHER after the first random byte → next cycle IDLE, z=0, out_valid=0. A new encoding then completes correctly with no residue in acc.
- v=2 and v=5 builds: encoding is correct and latency is v cycles with no stalls.
